// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared constants for the instruction fetch front end
package fetch_unit_pkg;

  localparam int ILEN    = 32;
  localparam int PC_STEP = 4;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - prefetch ring: in-order alloc, fill and pop with flush
// Optional FETCH_BYPASS_EN forwards a fill straight to the output when nothing is filled.
module fetch_queue
  import fetch_unit_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            alloc_valid,
  input  logic [XLEN-1:0] alloc_pc,
  input  logic            fill_valid,
  input  logic [ILEN-1:0] fill_data,
  input  logic            pop,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [ILEN-1:0] out_instr,
  output logic [PW-1:0]   alloc_cnt,
  output logic [PW-1:0]   pend
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
    logic            filled;
  } entry_t;

  entry_t [DEPTH-1:0] entries_q, entries_d;
  logic [PW-1:0]      head_q, head_d, tail_q, tail_d, fill_q, fill_d;
  logic [PW-2:0]      head_idx, tail_idx, fill_idx;
  logic               head_filled;

  assign head_idx  = head_q[PW-2:0];
  assign tail_idx  = tail_q[PW-2:0];
  assign fill_idx  = fill_q[PW-2:0];
  assign alloc_cnt = tail_q - head_q;
  assign pend      = tail_q - fill_q;
  // A popped slot keeps its stale filled bit until reallocated, so guard on occupancy.
  assign head_filled = entries_q[head_idx].filled && (alloc_cnt != '0);

`ifdef FETCH_BYPASS_EN
  logic bypass;
  assign bypass    = fill_valid && !flush && !head_filled;
  assign out_valid = head_filled || bypass;
  assign out_pc    = bypass ? entries_q[fill_idx].pc : entries_q[head_idx].pc;
  assign out_instr = bypass ? fill_data : entries_q[head_idx].instr;
`else
  assign out_valid = head_filled;
  assign out_pc    = entries_q[head_idx].pc;
  assign out_instr = entries_q[head_idx].instr;
`endif

  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    fill_d    = fill_q;
    if (flush) begin
      head_d = '0;
      tail_d = '0;
      fill_d = '0;
    end else begin
      if (alloc_valid) begin
        entries_d[tail_idx].pc     = alloc_pc;
        entries_d[tail_idx].instr  = '0;
        entries_d[tail_idx].filled = 1'b0;
        tail_d = tail_q + PW'(1);
      end
      if (fill_valid) begin
        entries_d[fill_idx].instr  = fill_data;
        entries_d[fill_idx].filled = 1'b1;
        fill_d = fill_q + PW'(1);
      end
      if (pop) begin
        head_d = head_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entries_q <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      fill_q    <= '0;
    end else begin
      entries_q <= entries_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      fill_q    <= fill_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32 fetch front end: variable-latency memory port, prefetch queue, redirect
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic            i_req_valid,
  input  logic            i_req_ready,
  output logic [XLEN-1:0] i_req_addr,
  input  logic            i_rsp_valid,
  input  logic [ILEN-1:0] i_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            de_valid,
  input  logic            de_ready,
  output logic [ILEN-1:0] de_instr,
  output logic [XLEN-1:0] de_pc
);

  localparam int PW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [PW-1:0]   discard_cnt_q, discard_cnt_d;
  logic [PW-1:0]   alloc_cnt, pend;
  logic            req_fire, rsp_fill, de_fire;

  // Memory may hold at most DEPTH requests, counting those whose responses will be dropped.
  assign i_req_valid = !rst && (alloc_cnt < PW'(DEPTH)) &&
                       (({1'b0, pend} + {1'b0, discard_cnt_q}) < (PW+1)'(DEPTH));
  assign i_req_addr  = fetch_pc_q;
  assign req_fire    = i_req_valid && i_req_ready;
  assign rsp_fill    = i_rsp_valid && (discard_cnt_q == '0) && !redirect_valid;
  assign de_fire     = de_valid && de_ready;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    discard_cnt_d = discard_cnt_q;
    if (redirect_valid) begin
      fetch_pc_d    = redirect_pc & ~XLEN'(3);
      discard_cnt_d = discard_cnt_q + pend + PW'(req_fire) - PW'(i_rsp_valid);
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
      end
      if (i_rsp_valid && (discard_cnt_q != '0)) begin
        discard_cnt_d = discard_cnt_q - PW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      discard_cnt_q <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      discard_cnt_q <= discard_cnt_d;
    end
  end

  fetch_queue #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk         (clk),
    .rst         (rst),
    .flush       (redirect_valid),
    .alloc_valid (req_fire),
    .alloc_pc    (fetch_pc_q),
    .fill_valid  (rsp_fill),
    .fill_data   (i_rsp_data),
    .pop         (de_fire),
    .out_valid   (de_valid),
    .out_pc      (de_pc),
    .out_instr   (de_instr),
    .alloc_cnt   (alloc_cnt),
    .pend        (pend)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit with an in-order memory model
module tb_fetch_unit;

  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
`ifdef FETCH_BYPASS_EN
  localparam int RSP_TO_DE = 0;
`else
  localparam int RSP_TO_DE = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req_valid, i_req_ready;
  logic [31:0] i_req_addr;
  logic        i_rsp_valid;
  logic [31:0] i_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        de_valid, de_ready;
  logic [31:0] de_instr, de_pc;

  fetch_unit #(.XLEN(XLEN), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_req_valid    (i_req_valid),
    .i_req_ready    (i_req_ready),
    .i_req_addr     (i_req_addr),
    .i_rsp_valid    (i_rsp_valid),
    .i_rsp_data     (i_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .de_valid       (de_valid),
    .de_ready       (de_ready),
    .de_instr       (de_instr),
    .de_pc          (de_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          lat;
    int          pre;
    logic [31:0] rpc;
    logic [31:0] exp_pc;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  vec_t        vecs[5];
  mreq_t       mq[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lat = 1;
  int          last_due = 0;
  int          n_de = 0;
  logic [31:0] exp_fetch, exp_de;
  logic        s_req_valid, s_de_valid, acc, de_hs;
  logic [31:0] s_req_addr, s_de_pc, s_de_instr;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_req_ready = 1'b0;
    i_rsp_valid = 1'b0;
    i_rsp_data = '0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    de_ready = 1'b0;
    mq.delete();
    last_due = 0;
    exp_fetch = RESET_PC;
    exp_de = RESET_PC;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock: drive at negedge, sample 1ns later, then update the reference model.
  task automatic step(input bit rdy, input bit redir, input logic [31:0] rpc, input bit dr);
    int due;
    @(negedge clk);
    i_req_ready = rdy;
    redirect_valid = redir;
    redirect_pc = rpc;
    de_ready = dr;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      i_rsp_valid = 1'b1;
      i_rsp_data = instr_of(mq[0].addr);
    end else begin
      i_rsp_valid = 1'b0;
      i_rsp_data = $urandom;
    end
    #1;
    s_req_valid = i_req_valid;
    s_req_addr = i_req_addr;
    s_de_valid = de_valid;
    s_de_pc = de_pc;
    s_de_instr = de_instr;
    acc = s_req_valid && rdy;
    de_hs = s_de_valid && dr;
    if (de_hs) begin
      chk("de_pc_order", s_de_pc, exp_de);
      chk("de_instr", s_de_instr, instr_of(exp_de));
      exp_de += 32'd4;
      n_de++;
    end
    if (acc) begin
      chk("req_addr_order", s_req_addr, exp_fetch);
      chk("outstanding_limit", 32'(mq.size() < DEPTH), 32'd1);
      exp_fetch += 32'd4;
      due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
      mq.push_back('{s_req_addr, due});
      last_due = due;
    end
    if (redir) begin
      exp_fetch = rpc & ~32'h3;
      exp_de = exp_fetch;
    end
    if (i_rsp_valid) void'(mq.pop_front());
    cyc++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int first_de;
    int n;
    bit got_addr, got_de;

    // {latency, cycles before redirect, redirect_pc, expected next fetch/first decode pc}
    vecs[0] = '{5, 2, 32'h0000_0102, 32'h0000_0100};
    vecs[1] = '{2, 2, 32'h0000_0300, 32'h0000_0300};
    vecs[2] = '{1, 3, 32'h0000_0203, 32'h0000_0200};
    vecs[3] = '{3, 6, 32'hFFFF_FFFE, 32'hFFFF_FFFC};
    vecs[4] = '{2, 0, 32'h0000_0041, 32'h0000_0040};

    i_req_ready = 1'b0;
    i_rsp_valid = 1'b0;
    i_rsp_data = '0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    de_ready = 1'b0;
    @(negedge clk);
    #1;
    chk("reset_req_valid", 32'(i_req_valid), 32'd0);
    chk("reset_de_valid", 32'(de_valid), 32'd0);
    chk("reset_de_instr", de_instr, 32'd0);
    chk("reset_de_pc", de_pc, 32'd0);

    // Streaming with latency 1: consecutive addresses, decode sees 0x0 after the fixed latency
    do_reset();
    lat = 1;
    first_de = -1;
    for (int i = 0; i < 5; i++) begin
      step(1, 0, '0, 1);
      chk("stream_addr", s_req_addr, RESET_PC + 32'(4 * i));
      if (first_de < 0 && s_de_valid) first_de = i;
    end
    chk("rsp_to_de_latency", 32'(first_de), 32'(1 + RSP_TO_DE));

    // Full queue: decode stalled, exactly DEPTH requests, resume one cycle after a pop
    do_reset();
    lat = 1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      step(1, 0, '0, 0);
      if (acc) n++;
    end
    chk("full_req_count", 32'(n), 32'(DEPTH));
    chk("full_req_valid", 32'(s_req_valid), 32'd0);
    step(1, 0, '0, 1);
    chk("full_pop_valid", 32'(s_de_valid), 32'd1);
    chk("full_pop_pc", s_de_pc, 32'h0);
    chk("full_still_stalled", 32'(s_req_valid), 32'd0);
    step(1, 0, '0, 0);
    chk("resume_req_valid", 32'(s_req_valid), 32'd1);
    chk("resume_req_addr", s_req_addr, 32'h10);

    // Memory stall: address held, no PC advance
    do_reset();
    lat = 3;
    step(1, 0, '0, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, '0, 1);
      chk("stall_req_valid", 32'(s_req_valid), 32'd1);
      chk("stall_req_addr", s_req_addr, 32'h4);
    end
    step(1, 0, '0, 1);
    chk("stall_release_accept", 32'(acc), 32'd1);
    chk("stall_release_addr", s_req_addr, 32'h4);
    step(1, 0, '0, 1);
    chk("stall_next_addr", s_req_addr, 32'h8);

    // Redirect table
    foreach (vecs[k]) begin
      do_reset();
      lat = vecs[k].lat;
      for (int i = 0; i < vecs[k].pre; i++) step(1, 0, '0, 1);
      step(1, 1, vecs[k].rpc, 1);
      got_addr = 1'b0;
      got_de = 1'b0;
      for (int i = 0; i < 40 && !(got_addr && got_de); i++) begin
        step(1, 0, '0, 1);
        if (!got_addr && acc) begin
          chk("redir_first_addr", s_req_addr, vecs[k].exp_pc);
          got_addr = 1'b1;
        end
        if (!got_de && de_hs) begin
          chk("redir_first_de_pc", s_de_pc, vecs[k].exp_pc);
          got_de = 1'b1;
        end
      end
      chk("redir_addr_seen", 32'(got_addr), 32'd1);
      chk("redir_de_seen", 32'(got_de), 32'd1);
    end

    // Reset while entries are queued: outputs drop without waiting for a clock
    do_reset();
    lat = 1;
    for (int i = 0; i < 4; i++) step(1, 0, '0, 0);
    chk("pre_reset_de_valid", 32'(s_de_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_reset_req_valid", 32'(i_req_valid), 32'd0);
    chk("mid_reset_de_valid", 32'(de_valid), 32'd0);
    do_reset();
    step(1, 0, '0, 1);
    chk("post_reset_req_valid", 32'(s_req_valid), 32'd1);
    chk("post_reset_addr", s_req_addr, RESET_PC);

    // Randomized traffic against the reference model
    do_reset();
    n_de = 0;
    for (int i = 0; i < 3000; i++) begin
      lat = int'($urandom_range(1, 6));
      step($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0, $urandom,
           $urandom_range(0, 2) != 0);
    end
    chk("random_progress", 32'(n_de > 300), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
